// File: rtl/cfi_log_queue.sv
// Multi-port CFI commit-log FIFO: accepts up to NR_COMMIT_PORTS logs per cycle and drains one per cycle
// towards the monitor mailbox, counting dropped logs and raising a fill-threshold interrupt.
package cfi_log_pkg;
  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] addr_pc;
    logic [63:0] addr_npc;
    logic [63:0] addr_target;
  } cfi_log_t;
endpackage

module cfi_log_queue
  import cfi_log_pkg::*;
#(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int DEPTH           = 8,
  parameter int DROP_CNT_W      = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  cfi_log_t [NR_COMMIT_PORTS-1:0]      log_i,
  input  logic [NR_COMMIT_PORTS-1:0]          log_valid_i,
  input  logic                                clear_i,
  input  logic                                flush_i,
  input  logic [$clog2(DEPTH):0]              threshold_i,
  output cfi_log_t                            out_log_o,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [$clog2(DEPTH):0]              fill_o,
  output logic [DROP_CNT_W-1:0]               drop_cnt_o,
  output logic                                overflow_o,
  output logic                                irq_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int SW = DROP_CNT_W + FW;

  logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [FW-1:0]         fill_q, fill_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  ovf_q, ovf_d, irq_q, irq_d;
  cfi_log_t              mem_q [DEPTH];

  logic                       pop;
  logic [FW-1:0]              n_req, free, n_acc, n_drop;
  logic [NR_COMMIT_PORTS-1:0] we;
  logic [AW-1:0]              waddr [NR_COMMIT_PORTS];
  logic [SW-1:0]              drop_sum;

  assign out_valid_o = (fill_q != '0);
  assign pop         = out_valid_o & out_ready_i;
  assign out_log_o   = mem_q[rd_q];
  assign fill_o      = fill_q;
  assign drop_cnt_o  = drop_q;
  assign overflow_o  = ovf_q;
  assign irq_o       = irq_q;

  always_comb begin
    n_req = '0;
    for (int p = 0; p < NR_COMMIT_PORTS; p++) n_req = n_req + FW'(log_valid_i[p]);
  end

  // A same-cycle pop frees a slot for this cycle's pushes.
  assign free   = FW'(DEPTH) - fill_q + FW'(pop);
  assign n_acc  = (n_req < free) ? n_req : free;
  assign n_drop = flush_i ? '0 : (n_req - n_acc);

  // Each valid port takes the slot given by its rank among lower-indexed valid ports.
  for (genvar gi = 0; gi < NR_COMMIT_PORTS; gi++) begin : g_port
    logic [FW-1:0] rank;
    always_comb begin
      rank = '0;
      for (int p = 0; p < gi; p++) rank = rank + FW'(log_valid_i[p]);
    end
    assign we[gi]    = log_valid_i[gi] && !flush_i && (rank < n_acc);
    assign waddr[gi] = wr_q + rank[AW-1:0];
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      if (we[p] && !rst_i) mem_q[waddr[p]] <= log_i[p];
    end
  end

  always_comb begin
    wr_d   = wr_q + n_acc[AW-1:0];
    rd_d   = rd_q + AW'(pop);
    fill_d = fill_q + n_acc - FW'(pop);
    if (flush_i) begin
      wr_d   = '0;
      rd_d   = '0;
      fill_d = '0;
    end
    // Drops land on top of a same-cycle clear, so a clear never hides a fresh drop.
    drop_sum = SW'(clear_i ? '0 : drop_q) + SW'(n_drop);
    drop_d   = (drop_sum > SW'({DROP_CNT_W{1'b1}})) ? '1 : drop_sum[DROP_CNT_W-1:0];
    ovf_d    = (ovf_q & ~clear_i) | (n_drop != '0);
    irq_d    = (threshold_i != '0) && (fill_d >= threshold_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
      drop_q <= '0;
      ovf_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fill_q <= fill_d;
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
      irq_q  <= irq_d;
    end
  end
endmodule

// File: doc/cfi_log_queue.md
Name: cfi_log_queue

Overview:
- Sits directly downstream of the CVA6 CFI filter stage.
- Collects up to NR_COMMIT_PORTS filtered CFI commit logs per cycle into a circular FIFO.
- Drains the FIFO one entry per cycle over a valid/ready stream towards the CFI monitor mailbox.
- Tracks dropped logs (saturating counter plus sticky overflow flag) and raises a level interrupt at a programmable fill threshold.

Parameters:
- NR_COMMIT_PORTS, 2, number of commit ports feeding logs per cycle.
- DEPTH, 8, FIFO entries; power of two, ≥ NR_COMMIT_PORTS.
- DROP_CNT_W, 16, width of the saturating drop counter.

Ports:
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  reset; asynchronous, active-high.
- log_i  in  NR_COMMIT_PORTS x cfi_log_t  filtered logs (instr, addr_pc, addr_npc, addr_target).
- log_valid_i  in  NR_COMMIT_PORTS  per-port log valid.
- clear_i  in  1  synchronous clear of drop counter and overflow flag.
- flush_i  in  1  synchronous FIFO flush.
- threshold_i  in  $clog2(DEPTH)+1  interrupt fill threshold; 0 disables the interrupt.
- out_log_o  out  cfi_log_t  head-of-FIFO log.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  consumer ready.
- fill_o  out  $clog2(DEPTH)+1  current occupancy.
- drop_cnt_o  out  DROP_CNT_W  saturating count of dropped logs.
- overflow_o  out  1  sticky: at least one log dropped since reset or clear.
- irq_o  out  1  registered level interrupt.

Behaviour:
- Reset (async, rst_i=1): rd/wr pointers=0, fill_o=0, out_valid_o=0, drop_cnt_o=0, overflow_o=0, irq_o=0. FIFO storage is not reset; out_log_o is don't-care while out_valid_o=0.
- Pop: occurs when out_valid_o & out_ready_i.
  - out_valid_o = (fill_o != 0).
  - out_log_o = storage[rd_ptr], combinational from registered state (zero-latency show-ahead).
- Push accounting:
  - n_req = popcount(log_valid_i).
  - free = DEPTH - fill_o + pop. A same-cycle pop frees space for same-cycle pushes.
  - n_acc = min(n_req, free).
  - Valid ports are accepted in ascending port index. The first n_acc valid ports are written to consecutive slots starting at wr_ptr. Invalid ports consume no slot.
  - The remaining n_req - n_acc valid ports are dropped.
- Pointers wrap modulo DEPTH.
  - Next fill_o = fill_o + n_acc - pop; never exceeds DEPTH, never underflows.
  - Entries appear on out_log_o the cycle after the write (push-to-head latency 1 cycle when empty).
- Drop tracking:
  - drop_cnt_o += number dropped, saturating at 2^DROP_CNT_W - 1 (no wrap).
  - overflow_o sets on any drop.
  - clear_i zeroes both. If clear_i and a drop occur in the same cycle, the drop wins: counter = dropped count, flag = 1.
- Flush:
  - flush_i resets pointers and fill to 0 next cycle.
  - Same-cycle pushes are discarded and not counted as drops.
  - Same-cycle pop handshake is still considered taken by the consumer.
  - drop_cnt_o and overflow_o are unaffected.
- Interrupt: irq_o registered; next irq_o = (threshold_i != 0) && (next fill ≥ threshold_i).
- Inputs are ignored while rst_i is asserted. Deasserting reset mid-stream yields an empty FIFO; no stale entries are presented.
- out_valid_o never depends combinationally on out_ready_i; the consumer may wait indefinitely.

Test Plan:
- Single push/pop: port0 valid instr=0x0000_0067 at cycle 0, out_ready_i=1 → out_valid_o=1 at cycle 1 with instr 0x67, fill_o 1→0 at cycle 2, drop_cnt_o=0.
- Dual-port ordering: both ports valid (port0 pc=0x100, port1 pc=0x200), out_ready_i=0 → fill_o=2; subsequent pops return pc 0x100 then 0x200. Port1-only valid the next cycle → written to the next slot.
- Full with drain: DEPTH=8 filled, out_ready_i=0, both ports valid → drop_cnt_o=2, overflow_o=1, fill_o=8. Then out_ready_i=1 with both valid → one accepted (free=1), drop_cnt_o=3.
- Wrap and saturation: 20 pushes/pops across the pointer wrap → data preserved in order. With DROP_CNT_W=4, 20 drops → drop_cnt_o=15.
- Clear vs drop collision: clear_i asserted in the same cycle as 1 drop → drop_cnt_o=1, overflow_o=1. clear_i alone → both 0.
- Flush, threshold and reset: threshold_i=4, fill reaches 4 → irq_o=1 on the following cycle. flush_i → fill_o=0 and irq_o=0 next cycle. Async rst_i mid-cycle → out_valid_o=0 immediately.
